// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier with generic exponent/fraction widths,
// RNE rounding, exception flags and a sideband tag, valid/ready on both sides.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int MW  = MAN_W + 1;
  localparam int PW  = 2 * MW;
  localparam int LZW = $clog2(PW) + 1;
  localparam int XW  = EXP_W + LZW + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);

  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3     = ~v3 | out_ready;
  assign load2     = ~v2 | load3;
  assign load1     = ~v1 | load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  // ---------------- S1: unpack, classify, exponent sum
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_emax, a_emin, b_emax, b_emin;
  logic               a_zero, a_inf, a_nan, a_snan;
  logic               b_zero, b_inf, b_nan, b_snan;
  logic               inf_zero, nan_c, inv_c, inf_c, zero_c;
  logic signed [XW-1:0] exp_sum;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign a_emax = &ea;
  assign a_emin = ~|ea;
  assign b_emax = &eb;
  assign b_emin = ~|eb;
  assign a_zero = a_emin & ~|fa;
  assign b_zero = b_emin & ~|fb;
  assign a_inf  = a_emax & ~|fa;
  assign b_inf  = b_emax & ~|fb;
  assign a_nan  = a_emax & |fa;
  assign b_nan  = b_emax & |fb;
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];

  assign inf_zero = (a_inf & b_zero) | (b_inf & a_zero);
  assign nan_c    = a_nan | b_nan | inf_zero;
  assign inv_c    = a_snan | b_snan | inf_zero;
  assign inf_c    = (a_inf | b_inf) & ~nan_c;
  assign zero_c   = (a_zero | b_zero) & ~nan_c & ~inf_c;

  // Subnormals share the exponent of the smallest normal.
  assign ea_eff  = a_emin ? EXP_W'(1) : ea;
  assign eb_eff  = b_emin ? EXP_W'(1) : eb;
  assign exp_sum = $signed({{(XW-EXP_W){1'b0}}, ea_eff})
                 + $signed({{(XW-EXP_W){1'b0}}, eb_eff}) - BIAS_X;

  logic                 s1_sign, s1_nan, s1_inv, s1_inf, s1_zero;
  logic signed [XW-1:0] s1_exp;
  logic [MW-1:0]        s1_ma, s1_mb;
  logic [TAG_W-1:0]     s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_inv  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s1_tag  <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign <= sa ^ sb;
        s1_nan  <= nan_c;
        s1_inv  <= inv_c;
        s1_inf  <= inf_c;
        s1_zero <= zero_c;
        s1_exp  <= exp_sum;
        s1_ma   <= {~a_emin, fa};
        s1_mb   <= {~b_emin, fb};
        s1_tag  <= in_tag;
      end
    end
  end

  // ---------------- S2: mantissa product
  logic                 s2_sign, s2_nan, s2_inv, s2_inf, s2_zero;
  logic signed [XW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic [TAG_W-1:0]     s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_nan  <= 1'b0;
      s2_inv  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_tag  <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inv  <= s1_inv;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
        s2_exp  <= s1_exp;
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
        s2_tag  <= s1_tag;
      end
    end
  end

  // ---------------- S3: normalise, denormalise, round, pack
  logic [LZW-1:0]       lz;
  logic signed [XW-1:0] lz_x, e_r, sh, exp_f;
  logic [XW-1:0]        sh_u;
  logic [PW-1:0]        nm, shifted;
  logic                 tiny, lost, g, r, st, rnd_up, ovf, inexact;
  logic [MW-1:0]        mant;
  logic [MW:0]          mant_r;
  logic [MAN_W-1:0]     frac_r;

  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (s2_prod[i]) lz = LZW'(PW - 1 - i);
    end
  end

  assign lz_x    = $signed({{(XW-LZW){1'b0}}, lz});
  assign e_r     = s2_exp + ONE_X - lz_x;
  assign nm      = s2_prod << lz;
  assign tiny    = e_r[XW-1] | (e_r == '0);
  assign sh      = ONE_X - e_r;
  assign sh_u    = tiny ? $unsigned(sh) : '0;
  assign shifted = nm >> sh_u;
  // Any bit lost by the subnormal shift makes the round-back differ.
  assign lost    = (shifted << sh_u) != nm;
  assign mant    = shifted[PW-1 -: MW];
  assign g       = shifted[MAN_W];
  assign r       = shifted[MAN_W-1];
  assign st      = (|shifted[MAN_W-2:0]) | lost;
  assign rnd_up  = g & (r | st | mant[0]);
  assign mant_r  = {1'b0, mant} + {{MW{1'b0}}, rnd_up};
  // A subnormal carrying into the hidden bit lands on exponent 1.
  assign exp_f   = tiny ? $signed({{(XW-1){1'b0}}, mant_r[MAN_W]})
                        : e_r + $signed({{(XW-1){1'b0}}, mant_r[MW]});
  assign ovf     = ~tiny & (exp_f >= EMAX_X);
  assign inexact = g | r | st | ovf;
  assign frac_r  = mant_r[MW] ? {MAN_W{1'b0}} : mant_r[MAN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        out_tag <= s2_tag;
        if (s2_nan) begin
          out_p     <= {s2_sign, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          out_flags <= {s2_inv, 3'b000};
        end else if (s2_inf) begin
          out_p     <= {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          out_flags <= 4'b0000;
        end else if (s2_zero) begin
          out_p     <= {s2_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          out_flags <= 4'b0000;
        end else if (ovf) begin
          out_p     <= {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          out_flags <= 4'b0101;
        end else begin
          out_p     <= {s2_sign, exp_f[EXP_W-1:0], frac_r};
          out_flags <= {1'b0, 1'b0, tiny & inexact, inexact};
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (binary32): scoreboard of expected results,
// handshake/hold monitor, latency and mid-flight reset checks.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_p;
  logic [7:0]  in_tag, out_tag;
  logic [3:0]  out_flags;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_tag  (out_tag),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] p;
    logic [7:0]  tag;
    logic [3:0]  f;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          inflight = 0;
  logic [31:0] drv_exp_p = '0;
  logic [3:0]  drv_exp_f = '0;
  logic        pat_en = 1'b0;
  int          pat_i = 0;
  logic [3:0]  pat = 4'b1001;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_p;
  logic [7:0]  prev_tag;
  logic [3:0]  prev_f;

  // Directed corner vectors: {a, b, expected product, expected flags}
  logic [31:0] v_a [11] = '{32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h00800000,
                            32'h00000001, 32'h007FFFFF, 32'h7F800001, 32'h3FC00000,
                            32'hFF7FFFFF, 32'h00000003, 32'h00000001};
  logic [31:0] v_b [11] = '{32'h3F800001, 32'h40000000, 32'h80000000, 32'h3F000000,
                            32'h3F000000, 32'h3F800001, 32'h3F800000, 32'h3FC00000,
                            32'h40000000, 32'h3F000000, 32'h00000001};
  logic [31:0] v_p [11] = '{32'h3F800002, 32'h7F800000, 32'hFFC00000, 32'h00400000,
                            32'h00000000, 32'h00800000, 32'h7FC00000, 32'h40100000,
                            32'hFF800000, 32'h00000002, 32'h00000000};
  logic [3:0]  v_f [11] = '{4'b0001, 4'b0101, 4'b1000, 4'b0000,
                            4'b0011, 4'b0011, 4'b1000, 4'b0000,
                            4'b0101, 4'b0011, 4'b0011};

  // Streaming vectors, all exact or special with no flags.
  logic [31:0] s_a [8] = '{32'h3F800000, 32'h40000000, 32'hBFC00000, 32'h3F000000,
                           32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00001};
  logic [31:0] s_b [8] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000,
                           32'h40A00000, 32'h40400000, 32'hC0000000, 32'h3F800000};
  logic [31:0] s_p [8] = '{32'h3F800000, 32'h40C00000, 32'hC0400000, 32'h3E800000,
                           32'h00000000, 32'h80000000, 32'hFF800000, 32'h7FC00000};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pat_en) begin
      out_ready = pat[pat_i];
      pat_i = (pat_i + 1) % 4;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                      input logic [31:0] p, input logic [3:0] f);
    logic acc;
    in_a = a;
    in_b = b;
    in_tag = tag;
    drv_exp_p = p;
    drv_exp_f = f;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb_q.size() > 0; n++) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic lat_send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                          input logic [31:0] p, input logic [3:0] f);
    send(a, b, tag, p, f);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'(k == 3));
      tick();
    end
  endtask

  // Output monitor: transfers are decided at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!(inflight == 3 && !out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_p", out_p, prev_p);
        chk("hold_tag", 32'(out_tag), 32'(prev_tag));
        chk("hold_flags", 32'(out_flags), 32'(prev_f));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("out_p", out_p, mon_e.p);
          chk("out_tag", 32'(out_tag), 32'(mon_e.tag));
          chk("out_flags", 32'(out_flags), 32'(mon_e.f));
        end
      end
      if (in_valid && in_ready) begin
        mon_e.p = drv_exp_p;
        mon_e.tag = in_tag;
        mon_e.f = drv_exp_f;
        sb_q.push_back(mon_e);
      end
      inflight = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      prev_p = out_p;
      prev_tag = out_tag;
      prev_f = out_flags;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", out_p, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic product and three-cycle latency
    lat_send(32'h40000000, 32'h40400000, 8'h5A, 32'h40C00000, 4'b0000);
    drain();

    // Rounding, overflow, specials, subnormals, back to back
    for (int i = 0; i < 11; i++) send(v_a[i], v_b[i], 8'(8'h20 + i), v_p[i], v_f[i]);
    in_valid = 1'b0;
    drain();

    // Streaming under out_ready pattern 1,0,0,1
    pat_i = 0;
    pat_en = 1'b1;
    for (int i = 0; i < 8; i++) send(s_a[i], s_b[i], 8'(8'h10 + i), s_p[i], 4'b0000);
    in_valid = 1'b0;
    pat_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(s_a[i], s_b[i], 8'(8'h30 + i), s_p[i], 4'b0000);
    in_valid = 1'b0;
    chk("full_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    inflight = 0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_p", out_p, 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (4) tick();
    lat_send(32'h3FC00000, 32'h40000000, 8'hA5, 32'h40400000, 4'b0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
